// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared types, defaults and helpers for the seq_fifo slice
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // One extra bit so a count of exactly DEPTH is representable
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_fifo_ptr.sv
// ============================================================================
// seq_fifo_ptr : binary FIFO pointer, address bits plus a wrap bit
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule : seq_fifo_ptr

`default_nettype wire

// File: rtl/seq_fifo.sv
// ============================================================================
// seq_fifo : first-word fall-through FIFO, valid/ready both sides, sticky errors
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_fifo
    import seq_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = FIFO_DEPTH_DEFAULT,
    localparam int CNT_W  = clog2_cnt(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_rd_ptr;
    fifo_err_t         r_err;

    logic w_empty;
    logic w_full;
    logic w_wr_fire;
    logic w_rd_fire;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                       (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]);
    assign w_wr_fire = in_valid && !w_full;
    assign w_rd_fire = out_ready && !w_empty;

    seq_fifo_ptr #(.PTR_W(CNT_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_fire),
        .ptr (r_wr_ptr)
    );

    seq_fifo_ptr #(.PTR_W(CNT_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_fire),
        .ptr (r_rd_ptr)
    );

    // Storage is deliberately left unreset; emptiness masks stale contents
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    // A new error event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            if (in_valid && w_full) begin
                r_err.overflow <= 1'b1;
            end else if (clr_err) begin
                r_err.overflow <= 1'b0;
            end
            if (out_ready && w_empty) begin
                r_err.underflow <= 1'b1;
            end else if (clr_err) begin
                r_err.underflow <= 1'b0;
            end
        end
    end

    // Wrap-bit pointers make the difference the exact occupancy 0..DEPTH
    assign count     = r_wr_ptr - r_rd_ptr;
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign overflow  = r_err.overflow;
    assign underflow = r_err.underflow;

endmodule : seq_fifo

`default_nettype wire

// File: tb/tb_seq_fifo.sv
// ============================================================================
// tb_seq_fifo : randomized self-checking bench for seq_fifo against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    seq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered queue plus two sticky bits
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;
    bit                m_unf;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_clock();
        bit full_now;
        bit empty_now;
        full_now  = (mq.size() == DEPTH);
        empty_now = (mq.size() == 0);
        if (in_valid && full_now) m_ovf = 1;
        else if (clr_err)         m_ovf = 0;
        if (out_ready && empty_now) m_unf = 1;
        else if (clr_err)           m_unf = 0;
        if (out_ready && !empty_now) void'(mq.pop_front());
        if (in_valid && !full_now)   mq.push_back(in_data);
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        check({tag, ".in_ready"},  in_ready,  mq.size() < DEPTH);
        check({tag, ".out_valid"}, out_valid, mq.size() != 0);
        check({tag, ".out_data"},  out_data,  exp_data);
        check({tag, ".count"},     count,     mq.size());
        check({tag, ".overflow"},  overflow,  m_ovf);
        check({tag, ".underflow"}, underflow, m_unf);
    endtask

    // Called at a negedge: drive, clock the DUT and model, then check at the next negedge
    task automatic step(input string tag, input bit iv, input logic [DATA_W-1:0] d,
                        input bit ordy, input bit clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        clr_err   = clr;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        model_reset();

        // Reset and idle
        repeat (10) @(negedge clk);
        rst = 1'b1;
        check_all("reset");
        check("reset.count_const", count, 0);
        step("idle", 0, 8'h00, 0, 0);

        // Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) step("fill", 1, 8'(i), 0, 0);
        check("fill.count8", count, DEPTH);
        check("fill.in_ready0", in_ready, 0);
        step("ovf", 1, 8'hFF, 0, 0);
        check("ovf.flag", overflow, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain.order", out_data, 8'(i));
            step("drain", 0, 8'h00, 1, 0);
        end
        check("drain.empty", out_valid, 0);
        step("clr", 0, 8'h00, 0, 1);

        // Fall-through latency
        step("ft", 1, 8'hA5, 0, 0);
        check("ft.data", out_data, 8'hA5);
        check("ft.count", count, 1);
        step("ft_rd", 0, 8'h00, 1, 0);

        // Simultaneous read/write at half-full
        for (int i = 0; i < 4; i++) step("half", 1, 8'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) begin
            step("rw", 1, 8'($urandom), 1, 0);
            check("rw.count4", count, 4);
        end
        for (int i = 0; i < 4; i++) step("half_drain", 0, 8'h00, 1, 0);

        // Underflow and clear
        step("unf", 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step("unf_hold", 0, 8'h00, 0, 0);
        check("unf.sticky", underflow, 1);
        step("unf_clr", 0, 8'h00, 0, 1);
        check("unf.cleared", underflow, 0);
        step("unf_setwins", 0, 8'h00, 1, 1);
        check("unf.setwins", underflow, 1);
        step("unf_clr2", 0, 8'h00, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
        end
        while (mq.size() != 0) step("rand_drain", 0, 8'h00, 1, 0);
        step("rand_clr", 0, 8'h00, 0, 1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 8'($urandom), 0, 0);
        check("pre_rst.count5", count, 5);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst.count", count, 0);
        check("arst.out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        check_all("post_rst");
        step("post_wr", 1, 8'h3C, 0, 0);
        check("post_wr.data", out_data, 8'h3C);
        step("post_rd", 0, 8'h00, 1, 0);
        check("post_rd.empty", out_valid, 0);
        step("post_idle", 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_fifo

`default_nettype wire
